// File: rtl/spi_access_pkg.sv
// Shared definitions for the SPI access responder: FSM state encoding and the
// default transfer geometry.
package spi_access_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_e;

  localparam int DEF_WORD_BITS = 16;
  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_CS_SETUP  = 2;

endpackage

// File: rtl/spi_sclk_div.sv
// SCLK generator: while enabled, sclk is low for CLK_DIV cycles and then high for
// CLK_DIV cycles; rise/fall strobe on the clk edge where sclk changes.
module spi_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic rise_o,
  output logic fall_o,
  output logic sclk_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          terminal;

  assign terminal = en_i && (cnt_q == LAST);
  assign rise_o   = terminal && !phase_q;
  assign fall_o   = terminal && phase_q;
  assign sclk_o   = phase_q;

  // Dropping enable parks the divider at the start of a low phase.
  always_comb begin
    cnt_d   = '0;
    phase_d = 1'b0;
    if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        phase_d = !phase_q;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        phase_d = phase_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_access_responder.sv
// Services a level access request with one mode-0, MSB-first SPI word transfer and
// returns the received word with a one-cycle ack; one extra request may queue.
module spi_access_responder
  import spi_access_pkg::*;
#(
  parameter int WORD_BITS = DEF_WORD_BITS,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int CS_SETUP  = DEF_CS_SETUP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic [WORD_BITS-1:0] cmd_word,
  input  logic                 ovr_clr,
  output logic                 busy,
  output logic                 ack,
  output logic [WORD_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 overrun,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int BW = $clog2(WORD_BITS + 1);
  localparam int SW = $clog2(CS_SETUP + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_BITS - 1);
  localparam logic [SW-1:0] WAIT_LAST = SW'(CS_SETUP - 1);

  state_e               state_q, state_d;
  logic                 req_d1_q;
  logic                 pending_q, pending_d;
  logic                 overrun_q, overrun_d;
  logic [SW-1:0]        wait_q, wait_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [WORD_BITS-1:0] tx_q, tx_d;
  logic [WORD_BITS-1:0] rx_q, rx_d;
  logic [WORD_BITS-1:0] rd_data_q, rd_data_d;
  logic                 req_rise;
  logic                 sclk_rise, sclk_fall;

  assign req_rise = req && !req_d1_q;

  spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q == SHIFT),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall),
    .sclk_o (sclk)
  );

  // A queued request is consumed in IDLE; a rise arriving in that same cycle
  // becomes the next queued request. The overrun set wins over a same-cycle clear.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    wait_d    = wait_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;

    if (ovr_clr) overrun_d = 1'b0;

    if (state_q != IDLE && req_rise) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (req_rise || pending_q) begin
          state_d   = SETUP;
          tx_d      = cmd_word;
          wait_d    = '0;
          pending_d = pending_q && req_rise;
        end
      end
      SETUP: begin
        if (wait_q == WAIT_LAST) begin
          state_d = SHIFT;
          bit_d   = '0;
        end else begin
          wait_d = wait_q + SW'(1);
        end
      end
      SHIFT: begin
        if (sclk_rise) rx_d = {rx_q[WORD_BITS-2:0], miso};
        if (sclk_fall) begin
          tx_d = {tx_q[WORD_BITS-2:0], 1'b0};
          if (bit_q == BIT_LAST) begin
            state_d = HOLD;
            wait_d  = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      HOLD: begin
        if (wait_q == WAIT_LAST) begin
          state_d   = DONE;
          rd_data_d = rx_q;
        end else begin
          wait_d = wait_q + SW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_d1_q  <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      wait_q    <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      req_d1_q  <= req;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      wait_q    <= wait_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign ack      = (state_q == DONE);
  assign rd_valid = (state_q == DONE);
  assign cs_n     = !(state_q == SETUP || state_q == SHIFT || state_q == HOLD);
  assign mosi     = tx_q[WORD_BITS-1];
  assign rd_data  = rd_data_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_access_responder.sv
// Bench for spi_access_responder: a transfer-timeline model checked every cycle
// against the default build, plus literal checks on both default and 8-bit builds.
module tb_spi_access_responder;

  localparam int WB        = 16;
  localparam int CD        = 4;
  localparam int CSS       = 2;
  localparam int SHIFT_LEN = 2 * CD * WB;
  localparam int L         = 2 * CSS + SHIFT_LEN;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        ovrClr = 1'b0;
  logic        miso;
  logic [15:0] cmdWord = '0;
  logic        busy, ack, rdValid, overrun, sclk, csN, mosi;
  logic [15:0] rdData;

  logic        req8 = 1'b0;
  logic [7:0]  cmd8 = '0;
  logic        busy8, ack8, rdValid8, overrun8, sclk8, csN8, mosi8;
  logic [7:0]  rdData8;

  always #5 clk = ~clk;

  spi_access_responder #(.WORD_BITS(WB), .CLK_DIV(CD), .CS_SETUP(CSS)) u_dut (
    .clk(clk), .rst(rst), .req(req), .cmd_word(cmdWord), .ovr_clr(ovrClr),
    .busy(busy), .ack(ack), .rd_data(rdData), .rd_valid(rdValid), .overrun(overrun),
    .sclk(sclk), .cs_n(csN), .mosi(mosi), .miso(miso)
  );

  spi_access_responder #(.WORD_BITS(8), .CLK_DIV(2), .CS_SETUP(2)) u_dut8 (
    .clk(clk), .rst(rst), .req(req8), .cmd_word(cmd8), .ovr_clr(1'b0),
    .busy(busy8), .ack(ack8), .rd_data(rdData8), .rd_valid(rdValid8), .overrun(overrun8),
    .sclk(sclk8), .cs_n(csN8), .mosi(mosi8), .miso(mosi8)
  );

  int vectors = 0;
  int miscompares = 0;
  int ackTotal = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Mode-0 slave: presents its MSB when selected and advances on each falling SCLK.
  logic        loopMode = 1'b1;
  logic [15:0] slaveWord = 16'h1234;
  int          slvIdx = 0;

  always @(negedge sclk or posedge csN)
    if (csN) slvIdx <= 0;
    else     slvIdx <= slvIdx + 1;

  assign miso = loopMode ? mosi : ((slvIdx < WB) ? slaveWord[WB-1-slvIdx] : 1'b0);

  // Model: mPos is the cycle index within the current transfer (0 = first cs_n-low
  // cycle, L = the ack cycle, -1 = idle).
  int          mPos = -1;
  logic        mPending = 1'b0, mOv = 1'b0, mReqD1 = 1'b0;
  logic [15:0] mCmd = '0, mExp = '0, mRd = '0;

  task automatic modelStep();
    logic reqRise;
    if (rst) begin
      mPos = -1; mPending = 1'b0; mOv = 1'b0; mReqD1 = 1'b0; mRd = '0;
    end else begin
      reqRise = req && !mReqD1;
      mReqD1  = req;
      if (ovrClr) mOv = 1'b0;
      if (mPos < 0) begin
        if (reqRise || mPending) begin
          mPos = 0;
          mCmd = cmdWord;
          mExp = loopMode ? cmdWord : slaveWord;
          mPending = mPending && reqRise;
        end
      end else begin
        if (reqRise) begin
          if (mPending) mOv = 1'b1;
          else          mPending = 1'b1;
        end
        if (mPos == L) mPos = -1;
        else begin
          mPos++;
          if (mPos == L) mRd = mExp;
        end
      end
    end
  endtask

  task automatic compareAll();
    logic expSclk;
    int   k;
    expSclk = 1'b0;
    if (mPos >= CSS && mPos < CSS + SHIFT_LEN) begin
      k = mPos - CSS;
      expSclk = (k % (2 * CD)) >= CD;
    end
    checkOutput("busy", busy, mPos >= 0);
    checkOutput("ack", ack, mPos == L);
    checkOutput("rd_valid", rdValid, mPos == L);
    checkOutput("cs_n", csN, !(mPos >= 0 && mPos < L));
    checkOutput("sclk", sclk, expSclk);
    checkOutput("overrun", overrun, mOv);
    checkOutput("rd_data", rdData, mRd);
    if (mPos >= 0 && mPos < CSS + SHIFT_LEN) begin
      k = (mPos < CSS) ? 0 : (mPos - CSS) / (2 * CD);
      checkOutput("mosi", mosi, mCmd[WB-1-k]);
    end
    if (ack) ackTotal++;
  endtask

  initial begin : scoreboard
    forever begin
      @(posedge clk or posedge rst);
      modelStep();
      #2;
      compareAll();
    end
  end

  task automatic applyStimulus(input logic r, input logic [15:0] cmd, input logic clr, input int n);
    @(negedge clk);
    req = r;
    cmdWord = cmd;
    ovrClr = clr;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic runTransfer(input logic [15:0] cmd, output int lowCnt, output int ackAt,
                             output int ackCnt, output logic [15:0] stream, output logic [15:0] rdSeen);
    logic prevSclk;
    lowCnt = 0; ackAt = -1; ackCnt = 0; stream = '0; rdSeen = '0; prevSclk = 1'b0;
    applyStimulus(1'b1, cmd, 1'b0, 1);
    for (int c = 1; c <= L + 20; c++) begin
      @(posedge clk);
      #2;
      if (!csN) lowCnt++;
      if (ack) begin
        ackCnt++;
        if (ackAt < 0) ackAt = c;
        if (rdValid) rdSeen = rdData;
      end
      if (sclk && !prevSclk) stream = {stream[14:0], mosi};
      prevSclk = sclk;
    end
    applyStimulus(1'b0, cmd, 1'b0, 3);
  endtask

  initial begin : stimulus
    int          lowCnt, ackAt, ackCnt, ackBefore;
    logic [15:0] stream, rdSeen;
    logic [7:0]  stream8, rd8;
    logic        prev8;

    applyStimulus(1'b0, 16'h0000, 1'b0, 3);
    checkOutput("reset_cs_n", csN, 1'b1);
    checkOutput("reset_sclk", sclk, 1'b0);
    checkOutput("reset_mosi", mosi, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_ack", {ack, rdValid}, 2'b00);
    checkOutput("reset_rd_data", rdData, 16'h0000);
    checkOutput("reset_overrun", overrun, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0, 3);

    $display("[TB] loopback transfer A5C3");
    runTransfer(16'hA5C3, lowCnt, ackAt, ackCnt, stream, rdSeen);
    checkOutput("loop_cs_low_cycles", lowCnt, 132);
    checkOutput("loop_ack_latency", ackAt, 133);
    checkOutput("loop_ack_count", ackCnt, 1);
    checkOutput("loop_mosi_stream", stream, 16'hA5C3);
    checkOutput("loop_rd_valid_data", rdSeen, 16'hA5C3);
    checkOutput("loop_rd_data_held", rdData, 16'hA5C3);

    $display("[TB] slave returns 1234");
    loopMode = 1'b0;
    runTransfer(16'h0F0F, lowCnt, ackAt, ackCnt, stream, rdSeen);
    checkOutput("slave_rd_data", rdSeen, 16'h1234);
    checkOutput("slave_mosi_stream", stream, 16'h0F0F);
    checkOutput("slave_cs_low_cycles", lowCnt, 132);
    loopMode = 1'b1;

    $display("[TB] req held high 1000 cycles");
    ackBefore = ackTotal;
    applyStimulus(1'b1, 16'h00FF, 1'b0, 1000);
    applyStimulus(1'b0, 16'h00FF, 1'b0, 3);
    checkOutput("held_req_acks", ackTotal - ackBefore, 1);
    checkOutput("held_req_rd_data", rdData, 16'h00FF);

    $display("[TB] queued request and overrun");
    ackBefore = ackTotal;
    applyStimulus(1'b1, 16'h1111, 1'b0, 10);
    applyStimulus(1'b0, 16'h1111, 1'b0, 10);
    applyStimulus(1'b1, 16'h1111, 1'b0, 10);
    applyStimulus(1'b0, 16'h2222, 1'b0, 10);
    applyStimulus(1'b1, 16'h2222, 1'b0, 5);
    checkOutput("overrun_set", overrun, 1'b1);
    applyStimulus(1'b0, 16'h2222, 1'b0, 300);
    checkOutput("queued_acks", ackTotal - ackBefore, 2);
    checkOutput("queued_rd_data", rdData, 16'h2222);
    checkOutput("overrun_sticky", overrun, 1'b1);
    applyStimulus(1'b0, 16'h2222, 1'b1, 1);
    applyStimulus(1'b0, 16'h2222, 1'b0, 2);
    checkOutput("overrun_cleared", overrun, 1'b0);

    $display("[TB] rising edge and clear in the same cycle");
    applyStimulus(1'b1, 16'h3333, 1'b0, 5);
    applyStimulus(1'b0, 16'h3333, 1'b0, 5);
    applyStimulus(1'b1, 16'h3333, 1'b0, 5);
    applyStimulus(1'b0, 16'h3333, 1'b0, 5);
    applyStimulus(1'b1, 16'h3333, 1'b1, 1);
    applyStimulus(1'b1, 16'h3333, 1'b0, 4);
    checkOutput("overrun_edge_beats_clr", overrun, 1'b1);
    applyStimulus(1'b0, 16'h3333, 1'b0, 300);
    applyStimulus(1'b0, 16'h3333, 1'b1, 1);
    applyStimulus(1'b0, 16'h3333, 1'b0, 2);

    $display("[TB] reset during shift");
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 49);
    checkOutput("pre_reset_sclk", sclk, 1'b1);
    checkOutput("pre_reset_cs_n", csN, 1'b0);
    ackBefore = ackTotal;
    #1;
    rst = 1'b1;
    req = 1'b0;
    #1;
    checkOutput("abort_cs_n", csN, 1'b1);
    checkOutput("abort_sclk", sclk, 1'b0);
    checkOutput("abort_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b0, 200);
    checkOutput("abort_no_ack", ackTotal - ackBefore, 0);
    runTransfer(16'h6E21, lowCnt, ackAt, ackCnt, stream, rdSeen);
    checkOutput("post_reset_cs_low", lowCnt, 132);
    checkOutput("post_reset_ack_count", ackCnt, 1);
    checkOutput("post_reset_rd_data", rdSeen, 16'h6E21);

    $display("[TB] 8-bit, CLK_DIV=2 build");
    lowCnt = 0; ackAt = -1; ackCnt = 0; stream8 = '0; rd8 = '0; prev8 = 1'b0;
    @(negedge clk);
    req8 = 1'b1;
    cmd8 = 8'h5A;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #2;
      if (!csN8) lowCnt++;
      if (ack8) begin
        ackCnt++;
        if (ackAt < 0) ackAt = c;
        if (rdValid8) rd8 = rdData8;
      end
      if (sclk8 && !prev8) stream8 = {stream8[6:0], mosi8};
      prev8 = sclk8;
    end
    @(negedge clk);
    req8 = 1'b0;
    checkOutput("w8_cs_low_cycles", lowCnt, 36);
    checkOutput("w8_ack_latency", ackAt, 37);
    checkOutput("w8_ack_count", ackCnt, 1);
    checkOutput("w8_mosi_stream", stream8, 8'h5A);
    checkOutput("w8_rd_data", rd8, 8'h5A);
    checkOutput("w8_idle_after", {busy8, overrun8, csN8}, 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
